// File: rtl/flag_branch_eval_pkg.sv
// Shared definitions for the flag-consumer blocks.
//  - FLG_* : bit positions of the condition flags inside the 8-bit flag bus
//  - cond_e : 4-bit branch condition codes
//  - state_e : branch resolution FSM states
package flag_pkg;

    localparam int FLG_C = 0;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 2;
    localparam int FLG_V = 3;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/flag_branch_eval_if.sv
// Branch request/response bundle between the fetch stage (master) and the
// branch evaluator (slave).
//  br_req/br_cond/br_target/pc_next : request side, driven by fetch
//  br_ack/br_taken/br_pc/br_err      : registered resolution result
//  stall                             : fetch hold while a decision is pending
interface flag_branch_eval_if #(
    parameter int AW = 16
);
    logic          br_req;
    logic [3:0]    br_cond;
    logic [AW-1:0] br_target;
    logic [AW-1:0] pc_next;
    logic          br_ack;
    logic          br_taken;
    logic [AW-1:0] br_pc;
    logic          br_err;
    logic          stall;

    modport master (
        output br_req, br_cond, br_target, pc_next,
        input  br_ack, br_taken, br_pc, br_err, stall
    );

    modport slave (
        input  br_req, br_cond, br_target, pc_next,
        output br_ack, br_taken, br_pc, br_err, stall
    );
endinterface

// File: rtl/flag_branch_eval_cond_eval.sv
// Combinational condition-code evaluator, shared with the conditional-move path.
//  flags[3:0] : C, Z, N, V
//  cond       : condition code
//  taken      : 1 when the condition holds for the given flags
module cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] flags,
    input  cond_e      cond,
    output logic       taken
);

    logic c_s;
    logic z_s;
    logic n_s;
    logic v_s;

    assign c_s = flags[FLG_C];
    assign z_s = flags[FLG_Z];
    assign n_s = flags[FLG_N];
    assign v_s = flags[FLG_V];

    // Decode the condition code against the flag bits.
    always_comb begin
        taken = 1'b0;
        case (cond)
            EQ:      taken = z_s;
            NE:      taken = ~z_s;
            CS:      taken = c_s;
            CC:      taken = ~c_s;
            MI:      taken = n_s;
            PL:      taken = ~n_s;
            VS:      taken = v_s;
            VC:      taken = ~v_s;
            HI:      taken = c_s & ~z_s;
            LS:      taken = ~c_s | z_s;
            GE:      taken = (n_s == v_s);
            LT:      taken = (n_s != v_s);
            GT:      taken = ~z_s & (n_s == v_s);
            LE:      taken = z_s | (n_s != v_s);
            AL:      taken = 1'b1;
            NV:      taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_eval.sv
// Branch evaluator: reads the registered flags, resolves a branch condition
// and returns taken/not-taken plus the next PC. Holds off the decision while a
// flag write is in flight, with a bounded wait that ends in a flagged forced
// resolution. Keeps a saturating count of taken branches.
//  CLK, Reset : clock, synchronous active-high reset
//  flags      : flag register output ([3:0] = C,Z,N,V; [7:4] reserved)
//  wrflag     : flag register loads new flags at the coming edge
//  cnt_clr    : clear taken_cnt (wins over a same-cycle increment)
//  taken_cnt  : saturating taken-branch count
//  bus        : branch request/response bundle (slave side)
module flag_branch_eval
    import flag_pkg::*;
#(
    parameter int AW       = 16,
    parameter int CNTW     = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic [7:0]          flags,
    input  logic                wrflag,
    input  logic                cnt_clr,
    output logic [CNTW-1:0]     taken_cnt,
    flag_branch_eval_if.slave   bus
);

    localparam int            WW        = $clog2(MAX_WAIT) + 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

    state_e          state_r;
    logic [WW-1:0]   wait_cnt_r;
    logic            ack_r;
    logic            taken_r;
    logic [AW-1:0]   pc_r;
    logic            err_r;
    logic [CNTW-1:0] cnt_r;

    logic            cond_taken_s;
    logic            eval_s;
    logic            force_s;
    logic            unused_flags_s;

    // Reserved flag bits carry no meaning for branch resolution.
    assign unused_flags_s = ^flags[7:4];

    cond_eval u_cond_eval (
        .flags (flags[3:0]),
        .cond  (cond_e'(bus.br_cond)),
        .taken (cond_taken_s)
    );

    // Decide whether this cycle resolves the branch, and whether it is forced.
    always_comb begin
        eval_s  = 1'b0;
        force_s = 1'b0;
        case (state_r)
            IDLE: begin
                eval_s = bus.br_req & ~wrflag;
            end
            WAIT: begin
                if (!wrflag) begin
                    eval_s = 1'b1;
                end else if (wait_cnt_r == WAIT_LAST) begin
                    // Flags still changing after the wait budget: resolve on
                    // what is visible now and report it.
                    eval_s  = 1'b1;
                    force_s = 1'b1;
                end else begin
                    eval_s = 1'b0;
                end
            end
            RESP: begin
                eval_s = 1'b0;
            end
            default: begin
                eval_s = 1'b0;
            end
        endcase
    end

    // Resolution FSM with wait counter and registered result/ack.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= '0;
            ack_r      <= 1'b0;
            taken_r    <= 1'b0;
            pc_r       <= '0;
            err_r      <= 1'b0;
        end else if (eval_s) begin
            taken_r <= cond_taken_s;
            pc_r    <= cond_taken_s ? bus.br_target : bus.pc_next;
            err_r   <= force_s;
            ack_r   <= 1'b1;
            state_r <= RESP;
        end else begin
            ack_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    // A request that did not resolve here has wrflag set.
                    if (bus.br_req) begin
                        wait_cnt_r <= '0;
                        state_r    <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    wait_cnt_r <= wait_cnt_r + WW'(1);
                    state_r    <= WAIT;
                end
                RESP: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Saturating taken-branch counter; clear wins over increment.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            cnt_r <= '0;
        end else if (cnt_clr) begin
            cnt_r <= '0;
        end else if (eval_s && cond_taken_s && (cnt_r != {CNTW{1'b1}})) begin
            cnt_r <= cnt_r + CNTW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign bus.br_ack   = ack_r;
    assign bus.br_taken = taken_r;
    assign bus.br_pc    = pc_r;
    assign bus.br_err   = err_r;
    // Stall goes high in the request cycle itself so fetch never runs ahead.
    assign bus.stall    = ((state_r == IDLE) & bus.br_req) | (state_r == WAIT);
    assign taken_cnt    = cnt_r;

endmodule
